norm_arbiter: RTL and testbench

NORM_ARBITER -- requirements
Module: norm_arbiter

---
 rtl/norm_arbiter.sv | 137 +++++++++++++
 tb/tb_norm_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/norm_arbiter.sv
// norm_arbiter: two-requester round-robin front end for a single shared
// combinational normalizer, with one registered result slot per requester.
// Optional feature: define NORM_ARB_BUSY_CNT_EN to add a saturating 16-bit
// busy_cnt output counting cycles in which a grant occurs.
module norm_arbiter #(
    parameter int EXP_WIDTH     = 5,
    parameter int MAN_IN_WIDTH  = 15,
    parameter int MAN_OUT_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*EXP_WIDTH-1:0]     req_exp,
    input  logic [2*MAN_IN_WIDTH-1:0]  req_man,
    output logic [EXP_WIDTH-1:0]       norm_exp_in,
    output logic [MAN_IN_WIDTH-1:0]    norm_man_in,
    input  logic [EXP_WIDTH-1:0]       norm_exp_out,
    input  logic [MAN_OUT_WIDTH-1:0]   norm_man_out,
    output logic [1:0]                 res_valid,
    input  logic [1:0]                 res_ready,
    output logic [2*EXP_WIDTH-1:0]     res_exp,
    output logic [2*MAN_OUT_WIDTH-1:0] res_man
`ifdef NORM_ARB_BUSY_CNT_EN
    ,
    output logic [15:0]                busy_cnt
`endif
);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t slot_state [2];
    slot_state_t slot_next  [2];
    logic        rr_ptr;
    logic [1:0]  slot_free;
    logic [1:0]  eligible;
    logic [1:0]  grant;

    // Eligibility and grant selection; reset forces no grant so req_ready stays low.
    always_comb begin
        slot_free = ~res_valid | res_ready;
        eligible  = req_valid & slot_free;
        grant     = 2'b00;
        if (rst_n) begin
            if (eligible == 2'b11) begin
                grant = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
        req_ready = grant;
    end

    // Steer the granted operand into the shared normalizer, zero when idle.
    always_comb begin
        norm_exp_in = '0;
        norm_man_in = '0;
        if (grant[1]) begin
            norm_exp_in = req_exp[EXP_WIDTH +: EXP_WIDTH];
            norm_man_in = req_man[MAN_IN_WIDTH +: MAN_IN_WIDTH];
        end else if (grant[0]) begin
            norm_exp_in = req_exp[0 +: EXP_WIDTH];
            norm_man_in = req_man[0 +: MAN_IN_WIDTH];
        end
    end

    // Per-slot next state: a grant always fills, a drain without grant empties.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_next[i] = slot_state[i];
            if (grant[i]) begin
                slot_next[i] = SLOT_FULL;
            end else if (slot_state[i] == SLOT_FULL && res_ready[i]) begin
                slot_next[i] = SLOT_EMPTY;
            end
        end
    end

    // Result valids are simply the decoded slot states.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            res_valid[i] = (slot_state[i] == SLOT_FULL);
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_state[0] <= SLOT_EMPTY;
            slot_state[1] <= SLOT_EMPTY;
        end else begin
            slot_state[0] <= slot_next[0];
            slot_state[1] <= slot_next[1];
        end
    end

    // Capture normalizer results into the granted slot; other slots hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_exp <= '0;
            res_man <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    res_exp[i*EXP_WIDTH +: EXP_WIDTH]         <= norm_exp_out;
                    res_man[i*MAN_OUT_WIDTH +: MAN_OUT_WIDTH] <= norm_man_out;
                end
            end
        end
    end

    // Round-robin pointer moves to the loser after each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant[0]) begin
            rr_ptr <= 1'b1;
        end else if (grant[1]) begin
            rr_ptr <= 1'b0;
        end
    end

`ifdef NORM_ARB_BUSY_CNT_EN
    // Saturating count of cycles in which the normalizer is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= 16'd0;
        end else if (|grant && busy_cnt != 16'hFFFF) begin
            busy_cnt <= busy_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_norm_arbiter.sv
// Directed testbench for norm_arbiter with a loopback normalizer model:
// norm_exp_out = norm_exp_in, norm_man_out = norm_man_in[14:5].
module tb_norm_arbiter;

    localparam int EW = 5;
    localparam int MW = 15;
    localparam int OW = 10;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2*EW-1:0] req_exp;
    logic [2*MW-1:0] req_man;
    logic [EW-1:0]   norm_exp_in;
    logic [MW-1:0]   norm_man_in;
    logic [EW-1:0]   norm_exp_out;
    logic [OW-1:0]   norm_man_out;
    logic [1:0]      res_valid;
    logic [1:0]      res_ready;
    logic [2*EW-1:0] res_exp;
    logic [2*OW-1:0] res_man;
`ifdef NORM_ARB_BUSY_CNT_EN
    logic [15:0]     busy_cnt;
`endif

    int vectors;
    int miscompares;

    norm_arbiter #(
        .EXP_WIDTH    (EW),
        .MAN_IN_WIDTH (MW),
        .MAN_OUT_WIDTH(OW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_exp     (req_exp),
        .req_man     (req_man),
        .norm_exp_in (norm_exp_in),
        .norm_man_in (norm_man_in),
        .norm_exp_out(norm_exp_out),
        .norm_man_out(norm_man_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_exp     (res_exp),
        .res_man     (res_man)
`ifdef NORM_ARB_BUSY_CNT_EN
        ,
        .busy_cnt    (busy_cnt)
`endif
    );

    // Loopback normalizer: pass exponent, keep the top mantissa bits.
    assign norm_exp_out = norm_exp_in;
    assign norm_man_out = norm_man_in[14:5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a new input vector just after the falling edge, then settle.
    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rready,
                                 input logic [EW-1:0] e0, input logic [MW-1:0] m0,
                                 input logic [EW-1:0] e1, input logic [MW-1:0] m1);
        @(negedge clk);
        req_valid = valid;
        res_ready = rready;
        req_exp   = {e1, e0};
        req_man   = {m1, m0};
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        req_valid   = 2'b11;
        res_ready   = 2'b11;
        req_exp     = '0;
        req_man     = '0;

        // Reset state, including req_ready held low despite requests.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset_res_exp", 32'(res_exp), 32'h0);
        checkOutput("reset_res_man", 32'(res_man), 32'h0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
`ifdef NORM_ARB_BUSY_CNT_EN
        #1;
        checkOutput("reset_busy_cnt", 32'(busy_cnt), 32'h0);
`endif

        // Single request from requester 0.
        $display("[TB] single request");
        applyStimulus(2'b01, 2'b11, 5'd10, 15'h5555, 5'd0, 15'h0);
        checkOutput("single_req_ready", 32'(req_ready), 32'h1);
        checkOutput("single_norm_exp_in", 32'(norm_exp_in), 32'd10);
        checkOutput("single_norm_man_in", 32'(norm_man_in), 32'h5555);
        clockEdge();
        checkOutput("single_res_valid", 32'(res_valid), 32'h1);
        checkOutput("single_res_exp0", 32'(res_exp[0 +: EW]), 32'd10);
        checkOutput("single_res_man0", 32'(res_man[0 +: OW]), 32'h2AA);
        applyStimulus(2'b00, 2'b11, 5'd0, 15'h0, 5'd0, 15'h0);
        checkOutput("idle_norm_exp_in", 32'(norm_exp_in), 32'h0);
        checkOutput("idle_norm_man_in", 32'(norm_man_in), 32'h0);
        clockEdge();
        checkOutput("drain_res_valid", 32'(res_valid), 32'h0);

        // Reset again so the tie test starts from rr_ptr = 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie: alternating grants 0,1,0,1.
        $display("[TB] round-robin tie");
        for (int c = 0; c < 4; c++) begin
            applyStimulus(2'b11, 2'b11, 5'd3, 15'h0400, 5'd7, 15'h7FE0);
            checkOutput("tie_req_ready", 32'(req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
            clockEdge();
            checkOutput("tie_res_valid", 32'(res_valid), (c % 2 == 0) ? 32'h1 : 32'h2);
        end
        checkOutput("tie_res_exp1", 32'(res_exp[EW +: EW]), 32'd7);
        checkOutput("tie_res_man1", 32'(res_man[OW +: OW]), 32'h3FF);
        checkOutput("tie_res_man0", 32'(res_man[0 +: OW]), 32'h020);
`ifdef NORM_ARB_BUSY_CNT_EN
        checkOutput("tie_busy_cnt", 32'(busy_cnt), 32'd4);
`endif
        applyStimulus(2'b00, 2'b11, 5'd0, 15'h0, 5'd0, 15'h0);
        clockEdge();
        checkOutput("tie_drain_res_valid", 32'(res_valid), 32'h0);

        // Backpressure on slot 0: one handshake, then stalled and stable.
        $display("[TB] backpressure");
        applyStimulus(2'b01, 2'b00, 5'd21, 15'h1234, 5'd0, 15'h0);
        checkOutput("bp_first_req_ready", 32'(req_ready), 32'h1);
        clockEdge();
        checkOutput("bp_first_res_valid", 32'(res_valid), 32'h1);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(2'b01, 2'b00, 5'd30, 15'h7FFF, 5'd0, 15'h0);
            checkOutput("bp_stall_req_ready", 32'(req_ready), 32'h0);
            checkOutput("bp_stall_norm_exp_in", 32'(norm_exp_in), 32'h0);
            clockEdge();
            checkOutput("bp_stall_res_valid", 32'(res_valid), 32'h1);
            checkOutput("bp_stall_res_exp0", 32'(res_exp[0 +: EW]), 32'd21);
            checkOutput("bp_stall_res_man0", 32'(res_man[0 +: OW]), 32'h091);
        end
        applyStimulus(2'b01, 2'b01, 5'd9, 15'h7C00, 5'd0, 15'h0);
        checkOutput("bp_drain_grant_req_ready", 32'(req_ready), 32'h1);
        clockEdge();
        checkOutput("bp_drain_grant_res_valid", 32'(res_valid), 32'h1);
        checkOutput("bp_drain_grant_res_exp0", 32'(res_exp[0 +: EW]), 32'd9);
        checkOutput("bp_drain_grant_res_man0", 32'(res_man[0 +: OW]), 32'h3E0);

        // Isolation: slot 0 stuck full, requester 1 keeps flowing.
        $display("[TB] isolation");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(2'b11, 2'b10, 5'd1, 15'h0FE0, 5'(17 + c), 15'((c + 1) << 5));
            checkOutput("iso_req_ready", 32'(req_ready), 32'h2);
            clockEdge();
            checkOutput("iso_res_valid", 32'(res_valid), 32'h3);
            checkOutput("iso_res_exp1", 32'(res_exp[EW +: EW]), 32'(17 + c));
            checkOutput("iso_res_man1", 32'(res_man[OW +: OW]), 32'(c + 1));
            checkOutput("iso_res_exp0", 32'(res_exp[0 +: EW]), 32'd9);
        end

        // Leave rr_ptr pointing at requester 1 with both slots full.
        applyStimulus(2'b10, 2'b11, 5'd0, 15'h0, 5'd4, 15'h0040);
        checkOutput("pre_rst_req_ready_a", 32'(req_ready), 32'h2);
        clockEdge();
        checkOutput("pre_rst_res_valid_a", 32'(res_valid), 32'h2);
        applyStimulus(2'b01, 2'b00, 5'd6, 15'h00A0, 5'd0, 15'h0);
        checkOutput("pre_rst_req_ready_b", 32'(req_ready), 32'h1);
        clockEdge();
        checkOutput("pre_rst_res_valid_b", 32'(res_valid), 32'h3);

        // Mid-operation reset: results discarded immediately, rr_ptr back to 0.
        $display("[TB] mid-operation reset");
        applyStimulus(2'b11, 2'b00, 5'd2, 15'h0, 5'd3, 15'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_res_valid", 32'(res_valid), 32'h0);
        checkOutput("midrst_res_exp", 32'(res_exp), 32'h0);
        checkOutput("midrst_req_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b11, 2'b11, 5'd12, 15'h0, 5'd13, 15'h0);
        checkOutput("midrst_tie_req_ready", 32'(req_ready), 32'h1);
        clockEdge();
        checkOutput("midrst_tie_res_valid", 32'(res_valid), 32'h1);
        checkOutput("midrst_tie_res_exp0", 32'(res_exp[0 +: EW]), 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
